// File: rtl/pf_pkg.sv
// Shared definitions for the frame transmitter: the Avalon register map,
// the CTRL and STATUS bit positions, and the frame FSM state type.
package pf_pkg;

  localparam logic [7:0] FT_REG_CTRL   = 8'd0;
  localparam logic [7:0] FT_REG_LEN    = 8'd1;
  localparam logic [7:0] FT_REG_SEED   = 8'd2;
  localparam logic [7:0] FT_REG_GAP    = 8'd3;
  localparam logic [7:0] FT_REG_STATUS = 8'd4;
  localparam logic [7:0] FT_REG_CKS0   = 8'd5;
  localparam logic [7:0] FT_REG_CKS1   = 8'd6;
  localparam logic [7:0] FT_REG_CKS2   = 8'd7;
  localparam logic [7:0] FT_REG_CKS3   = 8'd8;
  localparam logic [7:0] FT_REG_FRAMES = 8'd9;

  localparam int FT_CTRL_START  = 0;
  localparam int FT_CTRL_CONT   = 1;
  localparam int FT_STATUS_BUSY = 0;

  typedef enum logic [1:0] {
    FT_IDLE = 2'd0,
    FT_SEND = 2'd1,
    FT_GAP  = 2'd2
  } ft_state_t;

endpackage

// File: rtl/frame_tx_checksum.sv
// 32-bit payload checksum for the frame transmitter.
// Keeps a running sum of the accepted words of the frame in flight and a
// separate result register that only ever holds the sum of a whole frame.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   clear        restart the running sum at the beginning of a frame
//   acc_en       an accepted beat: add acc_data to the running sum
//   last         the accepted beat closes the frame: latch the final sum
//   acc_data     16-bit word of the accepted beat
//   checksum     sum of the last completed frame
module frame_tx_checksum (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        acc_en,
  input  logic        last,
  input  logic [15:0] acc_data,
  output logic [31:0] checksum
);

  logic [31:0] sum_q, sum_d;
  logic [31:0] chk_q, chk_d;
  logic [31:0] sum_next;

  assign sum_next = sum_q + {16'h0000, acc_data};

  // The final beat and the clear for a back-to-back restart can arrive in
  // the same cycle: the result register still takes the completed sum while
  // the running sum starts over.
  always_comb begin
    sum_d = sum_q;
    chk_d = chk_q;
    if (acc_en && last) begin
      chk_d = sum_next;
    end
    if (clear) begin
      sum_d = 32'h0;
    end else if (acc_en) begin
      sum_d = sum_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= 32'h0;
      chk_q <= 32'h0;
    end else begin
      sum_q <= sum_d;
      chk_q <= chk_d;
    end
  end

  assign checksum = chk_q;

endmodule

// File: rtl/frame_transmitter.sv
// Software-programmable AXI4-Stream frame source.
// Emits frames of LEN 16-bit words {SEED, word index} on egress_port,
// separated by GAP idle cycles, optionally repeating while CONTINUOUS is set.
// Ports:
//   clk, reset                      clock and asynchronous active-high reset
//   writedata/write/chipselect/
//   address/read/readdata           8-bit Avalon-MM slave, readdata registered
//   egress_port_tdata/tvalid/
//   egress_port_tready/tlast        16-bit AXI4-Stream master
module frame_transmitter #(
  parameter int LEN_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        read,
  output logic [7:0]  readdata,
  output logic [15:0] egress_port_tdata,
  output logic        egress_port_tvalid,
  input  logic        egress_port_tready,
  output logic        egress_port_tlast
);

  import pf_pkg::*;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  // Software-visible configuration
  logic                 cont_q, cont_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [7:0]           seed_q, seed_d;
  logic [7:0]           gap_q, gap_d;
  logic [7:0]           frames_q, frames_d;
  logic [7:0]           readdata_q, readdata_d;

  // Frame engine
  ft_state_t            state_q, state_d;
  logic [LEN_WIDTH-1:0] len_l_q, len_l_d;
  logic [7:0]           seed_l_q, seed_l_d;
  logic [LEN_WIDTH-1:0] k_q, k_d;
  logic [7:0]           gap_cnt_q, gap_cnt_d;

  logic        wr_en;
  logic        rd_en;
  logic        start_req;
  logic        can_launch;
  logic        restart;
  logic        launch;
  logic        sending;
  logic        tlast_int;
  logic [15:0] tdata_int;
  logic        beat_acc;
  logic [31:0] checksum;

  assign wr_en      = chipselect && write;
  assign rd_en      = chipselect && read;
  assign start_req  = wr_en && (address == FT_REG_CTRL) && writedata[FT_CTRL_START];
  assign can_launch = (len_q != '0);
  assign restart    = cont_q && can_launch;

  // Stream outputs come straight from flops so tvalid never looks at tready
  // and drops immediately when reset clears the state register.
  assign sending   = (state_q == FT_SEND);
  assign tdata_int = sending ? {seed_l_q, 8'(k_q)} : 16'h0000;
  assign tlast_int = sending && (k_q == (len_l_q - LEN_ONE));
  assign beat_acc  = sending && egress_port_tready;

  assign egress_port_tvalid = sending;
  assign egress_port_tdata  = tdata_int;
  assign egress_port_tlast  = tlast_int;
  assign readdata           = readdata_q;

  // Register writes; START is a pulse consumed by the FSM and never stored.
  always_comb begin
    cont_d = cont_q;
    len_d  = len_q;
    seed_d = seed_q;
    gap_d  = gap_q;
    if (wr_en) begin
      case (address)
        FT_REG_CTRL: cont_d = writedata[FT_CTRL_CONT];
        FT_REG_LEN:  len_d  = LEN_WIDTH'(writedata);
        FT_REG_SEED: seed_d = writedata;
        FT_REG_GAP:  gap_d  = writedata;
        default:     ;
      endcase
    end
  end

  // Register reads sample the state before this edge, so a checksum read in
  // the cycle the frame completes returns the previous frame's value.
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      case (address)
        FT_REG_STATUS: readdata_d = {7'h00, (state_q != FT_IDLE)};
        FT_REG_CKS0:   readdata_d = checksum[7:0];
        FT_REG_CKS1:   readdata_d = checksum[15:8];
        FT_REG_CKS2:   readdata_d = checksum[23:16];
        FT_REG_CKS3:   readdata_d = checksum[31:24];
        FT_REG_FRAMES: readdata_d = frames_q;
        default:       readdata_d = 8'h00;
      endcase
    end
  end

  // Frame FSM. LEN and SEED are copied into len_l/seed_l at every launch so
  // that software can reprogram them while a frame is in flight.
  always_comb begin
    state_d   = state_q;
    len_l_d   = len_l_q;
    seed_l_d  = seed_l_q;
    k_d       = k_q;
    gap_cnt_d = gap_cnt_q;
    frames_d  = frames_q;
    launch    = 1'b0;

    case (state_q)
      FT_IDLE: begin
        if (start_req && can_launch) begin
          launch = 1'b1;
        end
      end
      FT_SEND: begin
        if (beat_acc) begin
          k_d = k_q + LEN_ONE;
          if (tlast_int) begin
            frames_d = frames_q + 8'd1;
            if (gap_q != 8'd0) begin
              state_d   = FT_GAP;
              gap_cnt_d = gap_q;
            end else if (restart) begin
              launch = 1'b1;
            end else begin
              state_d = FT_IDLE;
            end
          end
        end
      end
      FT_GAP: begin
        // gap_cnt counts the idle cycles still to go, including this one.
        if (gap_cnt_q <= 8'd1) begin
          gap_cnt_d = 8'd0;
          if (restart) begin
            launch = 1'b1;
          end else begin
            state_d = FT_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = FT_IDLE;
      end
    endcase

    if (launch) begin
      state_d  = FT_SEND;
      len_l_d  = len_q;
      seed_l_d = seed_q;
      k_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cont_q     <= 1'b0;
      len_q      <= '0;
      seed_q     <= 8'h00;
      gap_q      <= 8'h00;
      frames_q   <= 8'h00;
      readdata_q <= 8'h00;
      state_q    <= FT_IDLE;
      len_l_q    <= '0;
      seed_l_q   <= 8'h00;
      k_q        <= '0;
      gap_cnt_q  <= 8'h00;
    end else begin
      cont_q     <= cont_d;
      len_q      <= len_d;
      seed_q     <= seed_d;
      gap_q      <= gap_d;
      frames_q   <= frames_d;
      readdata_q <= readdata_d;
      state_q    <= state_d;
      len_l_q    <= len_l_d;
      seed_l_q   <= seed_l_d;
      k_q        <= k_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  frame_tx_checksum u_checksum (
    .clk      (clk),
    .reset    (reset),
    .clear    (launch),
    .acc_en   (beat_acc),
    .last     (tlast_int),
    .acc_data (tdata_int),
    .checksum (checksum)
  );

endmodule

// File: tb/tb_frame_transmitter.sv
module tb_frame_transmitter;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  writedata;
  logic        write;
  logic        chipselect;
  logic [7:0]  address;
  logic        read;
  logic [7:0]  readdata;
  logic [15:0] egress_port_tdata;
  logic        egress_port_tvalid;
  logic        egress_port_tready;
  logic        egress_port_tlast;

  always #5 clk = ~clk;

  frame_transmitter #(.LEN_WIDTH(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .writedata          (writedata),
    .write              (write),
    .chipselect         (chipselect),
    .address            (address),
    .read               (read),
    .readdata           (readdata),
    .egress_port_tdata  (egress_port_tdata),
    .egress_port_tvalid (egress_port_tvalid),
    .egress_port_tready (egress_port_tready),
    .egress_port_tlast  (egress_port_tlast)
  );

  int errors = 0;
  int checks = 0;

  // tready policy: 0 always ready, 1 repeating 1,0,0 pattern, 2 random
  int rdy_mode  = 0;
  int rdy_phase = 0;

  // {tlast, tdata} of observed accepted beats and of beats the model predicts
  logic [16:0] mon_q[$];
  logic [16:0] exp_q[$];
  int          frames_model = 0;
  logic [31:0] cks_model    = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       egress_port_tready = 1'b1;
      1: begin
        egress_port_tready = (rdy_phase % 3 == 0);
        rdy_phase++;
      end
      default: egress_port_tready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    step();
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  // Reference: frame word k is seed*256 + (k mod 256); checksum is the plain sum.
  task automatic push_frame(input int len, input int seed);
    logic [31:0] s;
    logic [15:0] w;
    s = 32'h0;
    for (int k = 0; k < len; k++) begin
      w = 16'(((seed % 256) * 256) + (k % 256));
      exp_q.push_back({(k == len - 1), w});
      s = s + {16'h0000, w};
    end
    frames_model++;
    cks_model = s;
  endtask

  task automatic wait_beats(input string name, input int n);
    int b;
    b = 0;
    while (mon_q.size() < n && b < 4000) begin
      step();
      b++;
    end
    chk({name, "_beat_timeout"}, 32'(mon_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    logic [7:0] d;
    int b;
    b = 0;
    rd(8'd4, d);
    while (d[0] && b < 300) begin
      rd(8'd4, d);
      b++;
    end
    chk({name, "_idle"}, 32'(d), 32'd0);
  endtask

  task automatic check_stream(input string name);
    chk({name, "_beats"}, 32'(mon_q.size()), 32'(exp_q.size()));
    while (mon_q.size() > 0 && exp_q.size() > 0) begin
      chk({name, "_beat"}, 32'(mon_q.pop_front()), 32'(exp_q.pop_front()));
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic rd_cks(output logic [31:0] v);
    logic [7:0] b0, b1, b2, b3;
    rd(8'd5, b0); rd(8'd6, b1); rd(8'd7, b2); rd(8'd8, b3);
    v = {b3, b2, b1, b0};
  endtask

  task automatic check_regs(input string name);
    logic [31:0] c;
    logic [7:0]  f;
    rd_cks(c);
    chk({name, "_checksum"}, c, cks_model);
    rd(8'd9, f);
    chk({name, "_frames"}, 32'(f), 32'(frames_model % 256));
  endtask

  // Beat monitor and AXI hold check, sampled on the falling edge.
  logic        stall_p;
  logic [15:0] stall_data;
  logic        stall_last;
  initial begin
    stall_p = 1'b0;
    stall_data = 16'h0;
    stall_last = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_p = 1'b0;
      end else begin
        if (stall_p) begin
          chk("stall_hold",
              {14'h0, egress_port_tvalid, egress_port_tlast, egress_port_tdata},
              {14'h0, 1'b1, stall_last, stall_data});
        end
        if (egress_port_tvalid && egress_port_tready) begin
          mon_q.push_back({egress_port_tlast, egress_port_tdata});
        end
        stall_p    = egress_port_tvalid && !egress_port_tready;
        stall_data = egress_port_tdata;
        stall_last = egress_port_tlast;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          len;
    int          seed;
    int          gap;
    int          mode;
    logic [31:0] cks;
  } vec_t;

  vec_t        vecs[6];
  logic [7:0]  d8;
  logic [31:0] c32;
  logic [9:0]  pat;
  logic        seen;
  logic [31:0] old_cks;

  initial begin
    vecs[0] = '{4,   'hA5, 0, 0, 32'h00029406};
    vecs[1] = '{4,   'hA5, 0, 1, 32'h00029406};
    vecs[2] = '{1,   'h3C, 0, 0, 32'h00003C00};
    vecs[3] = '{3,   'h01, 2, 2, 32'h00000303};
    vecs[4] = '{2,   'hFF, 1, 1, 32'h0001FE01};
    vecs[5] = '{255, 'hFF, 0, 2, 32'h00FE7F81};

    reset = 1'b1; writedata = 8'h00; write = 1'b0; chipselect = 1'b0;
    address = 8'h00; read = 1'b0; egress_port_tready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_tvalid", 32'(egress_port_tvalid), 32'd0);
    chk("reset_tlast", 32'(egress_port_tlast), 32'd0);
    chk("reset_tdata", 32'(egress_port_tdata), 32'd0);
    chk("reset_readdata", 32'(readdata), 32'd0);
    reset = 1'b0;
    step();
    for (int a = 0; a <= 9; a++) begin
      rd(8'(a), d8);
      chk($sformatf("reset_reg%0d", a), 32'(d8), 32'd0);
    end
    rd(8'h20, d8);
    chk("unmapped_read", 32'(d8), 32'd0);

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      rdy_mode = vecs[i].mode;
      rdy_phase = 0;
      wr(8'd3, 8'(vecs[i].gap));
      wr(8'd1, 8'(vecs[i].len));
      wr(8'd2, 8'(vecs[i].seed));
      push_frame(vecs[i].len, vecs[i].seed);
      wr(8'd0, 8'h01);
      wait_beats($sformatf("vec%0d", i), vecs[i].len);
      wait_idle($sformatf("vec%0d", i));
      check_stream($sformatf("vec%0d", i));
      rd_cks(c32);
      chk($sformatf("vec%0d_checksum", i), c32, vecs[i].cks);
      rd(8'd9, d8);
      chk($sformatf("vec%0d_frames", i), 32'(d8), 32'(frames_model % 256));
    end

    // Checksum read in the cycle of the update returns the old value
    rdy_mode = 0;
    old_cks = cks_model;
    wr(8'd3, 8'd0);
    wr(8'd1, 8'd1);
    wr(8'd2, 8'h42);
    push_frame(1, 'h42);
    wr(8'd0, 8'h01);
    rd(8'd6, d8);
    chk("cks_read_collision_old", 32'(d8), 32'(old_cks[15:8]));
    rd(8'd6, d8);
    chk("cks_read_after_update", 32'(d8), 32'(cks_model[15:8]));
    wait_beats("collide", 1);
    wait_idle("collide");
    check_stream("collide");

    // Continuous mode: LEN=2, GAP=3, then CONTINUOUS cleared mid-frame
    rdy_mode = 0;
    wr(8'd3, 8'd3);
    wr(8'd1, 8'd2);
    wr(8'd2, 8'h6B);
    wr(8'd0, 8'h03);
    for (int j = 0; j < 10; j++) begin
      pat[9 - j] = egress_port_tvalid;
      step();
    end
    chk("cont_gap_pattern", 32'(pat), 32'(10'b1100011000));
    wr(8'd0, 8'h00);
    for (int f = 0; f < 3; f++) push_frame(2, 'h6B);
    wait_idle("cont_stop");
    check_stream("cont_stop");
    check_regs("cont_stop");

    // LEN=0 start is ignored
    wr(8'd3, 8'd0);
    wr(8'd1, 8'd0);
    wr(8'd0, 8'h01);
    seen = 1'b0;
    for (int j = 0; j < 6; j++) begin
      seen = seen | egress_port_tvalid;
      step();
    end
    chk("len0_tvalid", 32'(seen), 32'd0);
    rd(8'd4, d8);
    chk("len0_busy", 32'(d8), 32'd0);
    check_stream("len0");

    // START while busy ignored; LEN/SEED writes only affect the next frame
    rdy_mode = 1;
    rdy_phase = 0;
    wr(8'd1, 8'd4);
    wr(8'd2, 8'h11);
    push_frame(4, 'h11);
    wr(8'd0, 8'h01);
    step();
    wr(8'd0, 8'h01);
    wr(8'd1, 8'd2);
    wr(8'd2, 8'h22);
    wait_beats("busy_start", 4);
    wait_idle("busy_start");
    repeat (4) step();
    check_stream("busy_start");
    check_regs("busy_start");
    wr(8'd0, 8'h01);
    push_frame(2, 'h22);
    wait_beats("new_len", 2);
    wait_idle("new_len");
    check_stream("new_len");
    check_regs("new_len");

    // Reset during beat 2 of 4
    rdy_mode = 0;
    wr(8'd1, 8'd4);
    wr(8'd2, 8'h5A);
    wr(8'd0, 8'h01);
    step();
    #1;
    reset = 1'b1;
    #1;
    chk("midreset_tvalid", 32'(egress_port_tvalid), 32'd0);
    chk("midreset_tdata", 32'(egress_port_tdata), 32'd0);
    #3;
    reset = 1'b0;
    step();
    mon_q.delete();
    exp_q.delete();
    frames_model = 0;
    cks_model = 32'h0;
    for (int a = 0; a <= 9; a++) begin
      rd(8'(a), d8);
      chk($sformatf("midreset_reg%0d", a), 32'(d8), 32'd0);
    end
    wr(8'd1, 8'd3);
    wr(8'd2, 8'h07);
    push_frame(3, 'h07);
    wr(8'd0, 8'h01);
    wait_beats("post_reset", 3);
    wait_idle("post_reset");
    check_stream("post_reset");
    check_regs("post_reset");

    // Randomized frames against the reference model
    for (int i = 0; i < 8; i++) begin
      int len, seed, gap;
      len  = int'($urandom_range(1, 24));
      seed = int'($urandom_range(0, 255));
      gap  = int'($urandom_range(0, 4));
      rdy_mode = 2;
      wr(8'd3, 8'(gap));
      wr(8'd1, 8'(len));
      wr(8'd2, 8'(seed));
      push_frame(len, seed);
      wr(8'd0, 8'h01);
      wait_beats($sformatf("rand%0d", i), len);
      wait_idle($sformatf("rand%0d", i));
      check_stream($sformatf("rand%0d", i));
      check_regs($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
